bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
//
// PURPOSE
// - Shares one dual-port BRAM (1 read port, 1 write port, 1-cycle registered read) among NUM_REQ requesters.
// - Requesters: fetch, LSU, debug/loader. Independent round-robin arbitration for reads and for writes.
// - At most one read and one write reach the BRAM per cycle.
// - Read data is routed back to the owning requester one cycle after its grant.
//
// PARAMETERS
// - DATA_WIDTH  32  word width; must match the BRAM
// - ADDR_WIDTH  8   word address width; must match the BRAM
// - NUM_REQ     2   number of requesters, legal range 2..4
// - IDX_W       derived: $clog2(NUM_REQ); localparam, not overridable
//
// PORTS
// - clock           in   1                     single clock; all logic on posedge
// - reset           in   1                     synchronous, active-low
// - req_valid       in   NUM_REQ               request i is presented
// - req_write       in   NUM_REQ               1 = write, 0 = read
// - req_addr        in   NUM_REQ*ADDR_WIDTH    packed; slice i = addr of requester i
// - req_wdata       in   NUM_REQ*DATA_WIDTH    packed write data
// - req_ready       out  NUM_REQ               combinational grant; accept when valid & ready
// - rsp_valid       out  NUM_REQ               registered; read data valid for requester i
// - rsp_rdata       out  DATA_WIDTH            shared response bus (BRAM readData passthrough)
// - readEnable      out  1                     to BRAM
// - readAddress     out  ADDR_WIDTH            to BRAM
// - writeEnable     out  1                     to BRAM
// - writeAddress    out  ADDR_WIDTH            to BRAM
// - writeData       out  DATA_WIDTH            to BRAM
// - readData        in   DATA_WIDTH            from BRAM
//
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - rd_ptr = wr_ptr = 0; rsp_valid = 0; rd_owner = 0.
//   - While reset is low, req_ready = 0, readEnable = 0 and writeEnable = 0 (combinationally forced).
// - Read arbitration:
//   - Candidates are requesters with req_valid & ~req_write.
//   - Grant goes to the first candidate at index >= rd_ptr, wrapping modulo NUM_REQ.
//   - On a grant g: rd_ptr <= (g+1) mod NUM_REQ. With no grant, rd_ptr holds.
// - Write arbitration: identical, using req_valid & req_write and wr_ptr.
// - Outputs and ready:
//   - req_ready[i] = read grant i | write grant i. At most one read grant and one write grant are asserted per cycle.
//   - Address and data muxes select the granted slice. With no grant, addr/data = 0 and the enable = 0.
// - Read response timing:
//   - A read granted in cycle N sets rsp_valid[owner] = 1 in cycle N+1, for one cycle; all other bits are 0.
//   - rsp_rdata = readData in cycle N+1.
//   - Back-to-back reads by the same or different requesters are allowed every cycle (full throughput).
// - Same-cycle read and write to the same address: passed through unmodified. The BRAM forwards writeData, so the reader sees the new value.
// - Requester contract: valid, write, addr and wdata are held stable until ready. The arbiter does not latch requests.
// - Fairness: a continuously valid requester is granted within NUM_REQ cycles of its class (read or write).
// - Reset mid-operation:
//   - A read granted in the cycle before reset asserts produces no rsp_valid; reset wins.
//   - A write granted in the same cycle as reset is suppressed (writeEnable forced 0).
// - rsp_rdata is a don't-care when all rsp_valid bits are 0. Nothing may depend on it.
//
// STRUCTURE
// - Shared include mem_arb_defines.vh: NUM_REQ bounds check and the requester index constants REQ_FETCH=0, REQ_LSU=1, REQ_DBG=2.
// - Sub-module rr_arbiter #(N) (req[N], ptr[IDX_W] -> gnt[N] one-hot, gnt_idx, any).
//   - Purely combinational; instantiated twice (read, write).
//   - The pointer registers live in bram_port_arbiter.
// - Top level holds rd_ptr, wr_ptr, rd_owner and the rsp_valid register, plus the packed-slice muxes.
//
// TESTING
// - Reset: hold reset=0 with all req_valid=1 -> req_ready=0, both enables 0, rsp_valid=0. Release -> first grant goes to index 0.
// - Single read: NUM_REQ=2; req 1 reads addr 0x10 holding 0xDEADBEEF.
//   - Cycle N: ready[1]=1.
//   - Cycle N+1: rsp_valid=2'b10, rsp_rdata=0xDEADBEEF.
// - Contention: both requesters read continuously for 6 cycles -> grants alternate 0,1,0,1,0,1. rsp_valid follows one cycle later.
// - Concurrent read and write: req 0 writes 0x12345678 to 0x20 while req 1 reads 0x20 in the same cycle.
//   - Both ready=1 in that cycle.
//   - Next cycle: rsp_valid[1]=1, rsp_rdata=0x12345678 (BRAM bypass).
// - Reset mid-read: read granted at cycle N, reset=0 at cycle N+1 -> rsp_valid stays 0, pointers return to 0.
// - Fairness, NUM_REQ=3: all three write continuously for 9 cycles -> each granted exactly 3 times, no gap exceeds 3 cycles. Final memory contents match the last write per address.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter_pkg
// Purpose  : Shared constants and helpers for the BRAM port arbiter.
//            Holds the legal requester-count bounds, the conventional
//            requester index assignments and the wrapping pointer increment.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bram_port_arbiter_pkg;

  localparam int REQ_MIN = 2;
  localparam int REQ_MAX = 4;

  // Conventional requester slots on the packed request buses.
  localparam int REQ_FETCH = 0;
  localparam int REQ_LSU   = 1;
  localparam int REQ_DBG   = 2;

  // Next round-robin pointer after granting index idx among n requesters.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : bram_port_arbiter_pkg
`default_nettype wire

// File: rtl/bram_port_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Purely combinational round-robin picker. Grants the first
//            asserted request at index >= ptr, wrapping modulo N.
// Ports    : req     [N]      request vector
//            ptr     [IDX_W]  highest-priority index this cycle
//            gnt     [N]      one-hot grant (all zero when nothing requested)
//            gnt_idx [IDX_W]  binary index of the grant (0 when none)
//            any              a grant was issued
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Walk the requesters starting at ptr; the first hit wins.
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        found    = 1'b1;
      end
    end
    any = found;
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Purpose  : Shares one simple dual-port BRAM (1 read, 1 write, 1-cycle
//            registered read) among NUM_REQ requesters with independent
//            round-robin arbitration for reads and writes. Read data is
//            routed back to its owner one cycle after the grant.
// Ports    : clock, reset (sync, active-low)
//            req_valid/req_write [NUM_REQ], req_addr/req_wdata (packed slices)
//            req_ready [NUM_REQ]  combinational grant
//            rsp_valid [NUM_REQ]  one-hot read response, rsp_rdata shared bus
//            readEnable/readAddress, writeEnable/writeAddress/writeData -> BRAM
//            readData <- BRAM
// Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          readEnable,
  output logic [ADDR_WIDTH-1:0]         readAddress,
  output logic                          writeEnable,
  output logic [ADDR_WIDTH-1:0]         writeAddress,
  output logic [DATA_WIDTH-1:0]         writeData,
  input  logic [DATA_WIDTH-1:0]         readData
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < REQ_MIN || NUM_REQ > REQ_MAX) begin : g_num_req_check
    $error("bram_port_arbiter: NUM_REQ must be in 2..4");
  end

  logic [NUM_REQ-1:0] rd_req, wr_req, rd_gnt, wr_gnt;
  logic [IDX_W-1:0]   rd_idx, wr_idx;
  logic               rd_any, wr_any;

  logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]   rd_owner_q, rd_owner_d;
  logic               rd_pend_q, rd_pend_d;

  // Masking the candidates while reset is low kills every grant, ready and
  // enable in one place, including a write presented in the reset cycle.
  always_comb begin
    rd_req = '0;
    wr_req = '0;
    if (reset) begin
      rd_req = req_valid & ~req_write;
      wr_req = req_valid &  req_write;
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .req     (rd_req),
    .ptr     (rd_ptr_q),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx),
    .any     (rd_any)
  );

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .req     (wr_req),
    .ptr     (wr_ptr_q),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx),
    .any     (wr_any)
  );

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_owner_d = rd_owner_q;
    rd_pend_d  = rd_any;
    if (rd_any) begin
      rd_ptr_d   = IDX_W'(wrap_inc(int'(rd_idx), NUM_REQ));
      rd_owner_d = rd_idx;
    end
    if (wr_any) begin
      wr_ptr_d = IDX_W'(wrap_inc(int'(wr_idx), NUM_REQ));
    end
  end

  always_comb begin
    req_ready    = rd_gnt | wr_gnt;
    readEnable   = rd_any;
    readAddress  = '0;
    writeEnable  = wr_any;
    writeAddress = '0;
    writeData    = '0;
    if (rd_any) begin
      readAddress = req_addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end
    if (wr_any) begin
      writeAddress = req_addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      writeData    = req_wdata[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Response is decoded from registered owner/pending state. Gating with
  // reset drops a response whose grant happened just before reset fell.
  always_comb begin
    rsp_valid = '0;
    if (rd_pend_q && reset) begin
      rsp_valid[rd_owner_q] = 1'b1;
    end
    rsp_rdata = readData;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_owner_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_owner_q <= rd_owner_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

endmodule : bram_port_arbiter
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_arbiter
// Purpose  : Directed self-checking bench. A 2-requester instance covers
//            reset, single/contended reads, read/write bypass and reset in
//            mid-read; a 3-requester instance covers write fairness.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- NUM_REQ = 2 instance ----------------
  logic [1:0]  v2, w2, rdy2, rv2;
  logic [15:0] a2;
  logic [63:0] d2;
  logic [31:0] rdat2, wd2, bram_q2;
  logic        re2, we2;
  logic [7:0]  ra2, wa2;
  logic [31:0] mem2 [256] = '{default: 32'h0};

  bram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REQ(2)) dut2 (
    .clock(clk), .reset(rst_n),
    .req_valid(v2), .req_write(w2), .req_addr(a2), .req_wdata(d2),
    .req_ready(rdy2), .rsp_valid(rv2), .rsp_rdata(rdat2),
    .readEnable(re2), .readAddress(ra2),
    .writeEnable(we2), .writeAddress(wa2), .writeData(wd2),
    .readData(bram_q2)
  );

  // BRAM model: registered read, write data forwarded on address collision.
  always @(posedge clk) begin
    if (we2) mem2[wa2] <= wd2;
    if (re2) bram_q2 <= (we2 && wa2 == ra2) ? wd2 : mem2[ra2];
  end

  // ---------------- NUM_REQ = 3 instance ----------------
  logic [2:0]  v3, w3, rdy3, rv3;
  logic [23:0] a3;
  logic [95:0] d3;
  logic [31:0] rdat3, wd3, bram_q3;
  logic        re3, we3;
  logic [7:0]  ra3, wa3;
  logic [31:0] mem3 [256] = '{default: 32'h0};

  bram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REQ(3)) dut3 (
    .clock(clk), .reset(rst_n),
    .req_valid(v3), .req_write(w3), .req_addr(a3), .req_wdata(d3),
    .req_ready(rdy3), .rsp_valid(rv3), .rsp_rdata(rdat3),
    .readEnable(re3), .readAddress(ra3),
    .writeEnable(we3), .writeAddress(wa3), .writeData(wd3),
    .readData(bram_q3)
  );

  always @(posedge clk) begin
    if (we3) mem3[wa3] <= wd3;
    if (re3) bram_q3 <= (we3 && wa3 == ra3) ? wd3 : mem3[ra3];
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct packed {
    logic [1:0]  v;
    logic [31:0] d;
  } rsp_t;

  rsp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req2(input int i, input bit v, input bit w, input logic [7:0] a,
                      input logic [31:0] d);
    v2[i]         = v;
    w2[i]         = w;
    a2[i*8 +: 8]  = a;
    d2[i*32 +: 32] = d;
  endtask

  // One cycle on dut2: check combinational outputs for the current inputs,
  // check the response owed from the previous cycle, queue this cycle's.
  task automatic cyc2(input string tag, input logic [1:0] e_rdy, input bit e_re,
                      input bit e_we, input logic [1:0] p_v, input logic [31:0] p_d);
    rsp_t e;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(rdy2), 32'(e_rdy));
    chk({tag, ".readEnable"}, 32'(re2), 32'(e_re));
    chk({tag, ".writeEnable"}, 32'(we2), 32'(e_we));
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, ".rsp_valid"}, 32'(rv2), 32'(e.v));
    if (e.v != 2'b00) chk({tag, ".rsp_rdata"}, rdat2, e.d);
    sb.push_back('{v: p_v, d: p_d});
    @(posedge clk);
    #1;
  endtask

  int cnt [3];
  int last [3];

  initial begin
    rst_n = 1'b0;
    v2 = 2'b11; w2 = 2'b00; a2 = 16'h3130; d2 = '0;
    v3 = '0;    w3 = '0;    a3 = '0;       d3 = '0;
    sb.push_back('0);
    repeat (2) @(posedge clk);
    #1;

    // Reset with everything requesting: nothing granted, nothing enabled.
    cyc2("reset", 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);

    // Release: first read grant goes to index 0.
    rst_n = 1'b1;
    cyc2("release_first", 2'b01, 1'b1, 1'b0, 2'b01, 32'h0);
    req2(0, 0, 0, 8'h00, 32'h0);
    cyc2("second_rd", 2'b10, 1'b1, 1'b0, 2'b10, 32'h0);

    // Preload 0x10 through the write port.
    req2(1, 0, 0, 8'h00, 32'h0);
    req2(0, 1, 1, 8'h10, 32'hDEADBEEF);
    cyc2("preload_wr", 2'b01, 1'b0, 1'b1, 2'b00, 32'h0);

    // Single read by requester 1.
    req2(0, 0, 0, 8'h00, 32'h0);
    req2(1, 1, 0, 8'h10, 32'h0);
    cyc2("single_rd", 2'b10, 1'b1, 1'b0, 2'b10, 32'hDEADBEEF);

    // Continuous contention: grants alternate starting at 0.
    req2(0, 1, 0, 8'h10, 32'h0);
    req2(1, 1, 0, 8'h31, 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        cyc2($sformatf("contend%0d", k), 2'b01, 1'b1, 1'b0, 2'b01, 32'hDEADBEEF);
      else
        cyc2($sformatf("contend%0d", k), 2'b10, 1'b1, 1'b0, 2'b10, 32'h0);
    end

    // Same-cycle write and read of one address: reader sees new data.
    req2(0, 1, 1, 8'h20, 32'h12345678);
    req2(1, 1, 0, 8'h20, 32'h0);
    cyc2("rw_same_addr", 2'b11, 1'b1, 1'b1, 2'b10, 32'h12345678);
    req2(0, 0, 0, 8'h00, 32'h0);
    req2(1, 0, 0, 8'h00, 32'h0);
    cyc2("idle", 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);

    // Read granted, then reset falls: its response must never appear.
    req2(0, 1, 0, 8'h10, 32'h0);
    cyc2("mid_grant", 2'b01, 1'b1, 1'b0, 2'b00, 32'h0);
    req2(0, 0, 0, 8'h00, 32'h0);
    rst_n = 1'b0;
    cyc2("mid_reset", 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    rst_n = 1'b1;

    // Pointers back at 0 (both would favour 1 without the reset).
    req2(0, 1, 0, 8'h10, 32'h0);
    req2(1, 1, 0, 8'h20, 32'h0);
    cyc2("ptr_rd_after_rst", 2'b01, 1'b1, 1'b0, 2'b01, 32'hDEADBEEF);
    req2(0, 1, 1, 8'h41, 32'h000000A0);
    req2(1, 1, 1, 8'h42, 32'h000000A1);
    cyc2("ptr_wr_after_rst", 2'b01, 1'b0, 1'b1, 2'b00, 32'h0);
    req2(0, 0, 0, 8'h00, 32'h0);
    req2(1, 0, 0, 8'h00, 32'h0);
    cyc2("flush", 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);

    // Fairness on the 3-requester instance: all write for 9 cycles.
    for (int i = 0; i < 3; i++) begin
      cnt[i]  = 0;
      last[i] = -1;
      a3[i*8 +: 8] = 8'(8'h50 + i);
    end
    v3 = 3'b111;
    w3 = 3'b111;
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 3; i++)
        d3[i*32 +: 32] = 32'hF000_0000 | 32'(i << 8) | 32'(cnt[i]);
      @(negedge clk);
      chk($sformatf("fair_ready%0d", k), 32'(rdy3), 32'(3'b001 << (k % 3)));
      chk($sformatf("fair_we%0d", k), 32'(we3), 32'd1);
      for (int i = 0; i < 3; i++) begin
        if (rdy3[i]) begin
          chk($sformatf("fair_gap_req%0d_cyc%0d", i, k), 32'(k - last[i] <= 3), 32'd1);
          last[i] = k;
          cnt[i]++;
        end
      end
      @(posedge clk);
      #1;
    end
    v3 = 3'b000;
    w3 = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fair_count%0d", i), 32'(cnt[i]), 32'd3);
      chk($sformatf("fair_mem%0d", i), mem3[8'h50 + i], 32'hF000_0000 | 32'(i << 8) | 32'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bram_port_arbiter
`default_nettype wire
